// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter
//   Shares the single register-file write port between the pipeline
//   writeback stage (P) and a long-latency unit (L). Pending L results sit in
//   a 2-entry in-order FIFO. An effective P write always wins. The FIFO head
//   is next in line. An L result accepted into an empty FIFO bypasses it when
//   P is idle. An age counter on the FIFO head raises stall_o so that the
//   pipeline inserts a writeback bubble and the head can drain.
//
// Ports
//   clk_i, rst_n_i         clock, asynchronous active-low reset
//   P_wen_i/P_rd_i/P_data_i pipeline writeback request
//   L_valid_i/L_rd_i/L_data_i, L_ready_o  long-latency result handshake
//   RF_wen_o/RF_rd_o/RF_data_o  registered register-file write port
//   stall_o                registered writeback-bubble request
module regfile_wr_arbiter #(
    parameter int XLEN    = 32,
    parameter int AGE_MAX = 3
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            P_wen_i,
    input  logic [4:0]      P_rd_i,
    input  logic [XLEN-1:0] P_data_i,
    input  logic            L_valid_i,
    input  logic [4:0]      L_rd_i,
    input  logic [XLEN-1:0] L_data_i,
    output logic            L_ready_o,
    output logic            RF_wen_o,
    output logic [4:0]      RF_rd_o,
    output logic [XLEN-1:0] RF_data_o,
    output logic            stall_o
);

    localparam int AW = (AGE_MAX < 1) ? 1 : $clog2(AGE_MAX + 1);
    localparam logic [AW-1:0] AGE_SAT = AW'(AGE_MAX);

    typedef enum logic [1:0] {IDLE, PEND, STARVE} state_t;

    state_t          state_reg, state_next;
    logic [1:0]      count_reg, count_next;
    logic [AW-1:0]   age_reg, age_next;
    logic [4:0]      q_rd_reg   [2];
    logic [XLEN-1:0] q_data_reg [2];
    logic [4:0]      q_rd_next  [2];
    logic [XLEN-1:0] q_data_next[2];

    logic            wen_reg, wen_next;
    logic [4:0]      rd_reg, rd_next;
    logic [XLEN-1:0] data_reg, data_next;
    logic            stall_reg;

    logic            p_eff, l_acc, l_keep;
    logic [1:0]      kill, valid;
    logic [4:0]      c_rd   [2];
    logic [XLEN-1:0] c_data [2];
    logic [1:0]      c_cnt;
    logic            pop, bypass, push, head_killed;

    assign L_ready_o = (count_reg != 2'd2);
    assign p_eff     = P_wen_i && (P_rd_i != 5'd0);
    assign l_acc     = L_valid_i && L_ready_o;
    // An L result is older than the concurrent P instruction, so a P write to
    // the same register makes the L result dead on arrival.
    assign l_keep    = l_acc && (L_rd_i != 5'd0) && !(p_eff && (L_rd_i == P_rd_i));

    // Per-entry WAW kill and occupancy.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            assign kill[gi]  = p_eff && (q_rd_reg[gi] == P_rd_i);
            assign valid[gi] = (count_reg > 2'(gi)) && !kill[gi];
        end
    endgenerate

    assign head_killed = (count_reg != 2'd0) && kill[0];

    // Datapath: compact surviving entries, select the writer, pop and push.
    always_comb begin
        c_rd[0]   = q_rd_reg[0];
        c_rd[1]   = q_rd_reg[1];
        c_data[0] = q_data_reg[0];
        c_data[1] = q_data_reg[1];
        c_cnt     = 2'd0;
        if (valid[0]) begin
            c_cnt = valid[1] ? 2'd2 : 2'd1;
        end else if (valid[1]) begin
            c_rd[0]   = q_rd_reg[1];
            c_data[0] = q_data_reg[1];
            c_cnt     = 2'd1;
        end

        pop    = !p_eff && (c_cnt != 2'd0);
        bypass = !p_eff && (c_cnt == 2'd0) && l_keep;
        push   = l_keep && !bypass;

        q_rd_next[0]   = c_rd[0];
        q_rd_next[1]   = c_rd[1];
        q_data_next[0] = c_data[0];
        q_data_next[1] = c_data[1];
        count_next     = c_cnt;
        if (pop) begin
            q_rd_next[0]   = c_rd[1];
            q_data_next[0] = c_data[1];
            count_next     = c_cnt - 2'd1;
        end
        // A push never meets a full FIFO: L_ready_o is low at count 2.
        if (push) begin
            if (count_next == 2'd0) begin
                q_rd_next[0]   = L_rd_i;
                q_data_next[0] = L_data_i;
            end else begin
                q_rd_next[1]   = L_rd_i;
                q_data_next[1] = L_data_i;
            end
            count_next = count_next + 2'd1;
        end

        wen_next  = p_eff || pop || bypass;
        rd_next   = rd_reg;
        data_next = data_reg;
        if (p_eff) begin
            rd_next   = P_rd_i;
            data_next = P_data_i;
        end else if (pop) begin
            rd_next   = c_rd[0];
            data_next = c_data[0];
        end else if (bypass) begin
            rd_next   = L_rd_i;
            data_next = L_data_i;
        end

        // Age tracks how long the current head has waited; any new head
        // (pushed into empty, exposed by pop or by a WAW kill) starts at 0.
        if ((count_next == 2'd0) || pop || head_killed || (c_cnt == 2'd0))
            age_next = '0;
        else if (age_reg == AGE_SAT)
            age_next = AGE_SAT;
        else
            age_next = age_reg + AW'(1);
    end

    // Next-state logic of the starvation FSM.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (count_next != 2'd0)
                    state_next = (age_next == AGE_SAT) ? STARVE : PEND;
            end
            PEND: begin
                if (count_next == 2'd0)
                    state_next = IDLE;
                else if (age_next == AGE_SAT)
                    state_next = STARVE;
            end
            STARVE: begin
                if (count_next == 2'd0)
                    state_next = IDLE;
                else if (age_next != AGE_SAT)
                    state_next = PEND;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_reg     <= IDLE;
            count_reg     <= 2'd0;
            age_reg       <= '0;
            q_rd_reg[0]   <= 5'd0;
            q_rd_reg[1]   <= 5'd0;
            q_data_reg[0] <= '0;
            q_data_reg[1] <= '0;
            wen_reg       <= 1'b0;
            rd_reg        <= 5'd0;
            data_reg      <= '0;
            stall_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            age_reg       <= age_next;
            q_rd_reg[0]   <= q_rd_next[0];
            q_rd_reg[1]   <= q_rd_next[1];
            q_data_reg[0] <= q_data_next[0];
            q_data_reg[1] <= q_data_next[1];
            wen_reg       <= wen_next;
            rd_reg        <= rd_next;
            data_reg      <= data_next;
            stall_reg     <= (state_next == STARVE);
        end
    end

    assign RF_wen_o  = wen_reg;
    assign RF_rd_o   = rd_reg;
    assign RF_data_o = data_reg;
    assign stall_o   = stall_reg;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter (XLEN=32, AGE_MAX=3).
module tb_regfile_wr_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        P_wen_i = 1'b0;
    logic [4:0]  P_rd_i = 5'd0;
    logic [31:0] P_data_i = 32'd0;
    logic        L_valid_i = 1'b0;
    logic [4:0]  L_rd_i = 5'd0;
    logic [31:0] L_data_i = 32'd0;
    logic        L_ready_o;
    logic        RF_wen_o;
    logic [4:0]  RF_rd_o;
    logic [31:0] RF_data_o;
    logic        stall_o;

    int n_cmp = 0;
    int n_err = 0;

    regfile_wr_arbiter #(.XLEN(32), .AGE_MAX(3)) dut (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .P_wen_i   (P_wen_i),
        .P_rd_i    (P_rd_i),
        .P_data_i  (P_data_i),
        .L_valid_i (L_valid_i),
        .L_rd_i    (L_rd_i),
        .L_data_i  (L_data_i),
        .L_ready_o (L_ready_o),
        .RF_wen_o  (RF_wen_o),
        .RF_rd_o   (RF_rd_o),
        .RF_data_o (RF_data_o),
        .stall_o   (stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one rising edge and settle; outputs then show the edge's result.
    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_wr(input string tag, input logic wen, input logic [4:0] rd,
                          input logic [31:0] data);
        chk({tag, ".wen"}, 64'(RF_wen_o), 64'(wen));
        chk({tag, ".rd"}, 64'(RF_rd_o), 64'(rd));
        chk({tag, ".data"}, 64'(RF_data_o), 64'(data));
    endtask

    task automatic set_p(input logic wen, input logic [4:0] rd, input logic [31:0] data);
        P_wen_i = wen; P_rd_i = rd; P_data_i = data;
    endtask

    task automatic set_l(input logic v, input logic [4:0] rd, input logic [31:0] data);
        L_valid_i = v; L_rd_i = rd; L_data_i = data;
    endtask

    initial begin
        // Reset values
        #2;
        chk_wr("rst", 1'b0, 5'd0, 32'd0);
        chk("rst.stall", 64'(stall_o), 64'd0);
        chk("rst.ready", 64'(L_ready_o), 64'd1);
        #10 rst_n_i = 1'b1;
        cyc();
        chk("rst.idle_wen", 64'(RF_wen_o), 64'd0);

        // P only
        set_p(1'b1, 5'd5, 32'hA5);
        cyc();
        chk_wr("p5", 1'b1, 5'd5, 32'hA5);
        set_p(1'b1, 5'd0, 32'h33);
        cyc();
        chk_wr("p0_hold", 1'b0, 5'd5, 32'hA5);
        set_p(1'b0, 5'd0, 32'h0);

        // Bypass from idle
        set_l(1'b1, 5'd7, 32'h11);
        #1 chk("byp.ready", 64'(L_ready_o), 64'd1);
        cyc();
        chk_wr("byp", 1'b1, 5'd7, 32'h11);
        chk("byp.ready_after", 64'(L_ready_o), 64'd1);
        set_l(1'b0, 5'd0, 32'h0);
        cyc();
        chk("byp.idle", 64'(RF_wen_o), 64'd0);

        // L with rd 0 is discarded
        set_l(1'b1, 5'd0, 32'h77);
        cyc();
        set_l(1'b0, 5'd0, 32'h0);
        chk("l_rd0.wen", 64'(RF_wen_o), 64'd0);
        cyc();
        chk("l_rd0.wen2", 64'(RF_wen_o), 64'd0);

        // Full FIFO and ordered drain
        set_p(1'b1, 5'd1, 32'h100);
        set_l(1'b1, 5'd2, 32'h22);
        cyc();
        chk_wr("full.p1", 1'b1, 5'd1, 32'h100);
        chk("full.ready1", 64'(L_ready_o), 64'd1);
        set_l(1'b1, 5'd3, 32'h33);
        cyc();
        chk("full.ready0", 64'(L_ready_o), 64'd0);
        set_l(1'b1, 5'd4, 32'h44);
        cyc();
        chk("full.held", 64'(L_ready_o), 64'd0);
        chk_wr("full.p1b", 1'b1, 5'd1, 32'h100);
        set_p(1'b0, 5'd0, 32'h0);
        cyc();
        chk_wr("full.pop2", 1'b1, 5'd2, 32'h22);
        chk("full.ready_again", 64'(L_ready_o), 64'd1);
        cyc();
        chk_wr("full.pop3", 1'b1, 5'd3, 32'h33);
        set_l(1'b0, 5'd0, 32'h0);
        cyc();
        chk_wr("full.pop4", 1'b1, 5'd4, 32'h44);
        chk("full.stall", 64'(stall_o), 64'd0);
        cyc();
        chk("full.idle", 64'(RF_wen_o), 64'd0);

        // Starvation
        set_p(1'b1, 5'd1, 32'h100);
        set_l(1'b1, 5'd8, 32'h88);
        cyc();
        set_l(1'b0, 5'd0, 32'h0);
        chk("stv.s0", 64'(stall_o), 64'd0);
        cyc();
        chk("stv.s1", 64'(stall_o), 64'd0);
        cyc();
        chk("stv.s2", 64'(stall_o), 64'd0);
        cyc();
        chk("stv.s3", 64'(stall_o), 64'd1);
        chk_wr("stv.pwins", 1'b1, 5'd1, 32'h100);
        cyc();
        chk("stv.s4", 64'(stall_o), 64'd1);
        set_p(1'b0, 5'd0, 32'h0);
        cyc();
        chk_wr("stv.drain", 1'b1, 5'd8, 32'h88);
        chk("stv.clear", 64'(stall_o), 64'd0);
        cyc();
        chk("stv.idle", 64'(RF_wen_o), 64'd0);

        // WAW against a buffered entry
        set_p(1'b1, 5'd1, 32'h100);
        set_l(1'b1, 5'd9, 32'h1);
        cyc();
        set_l(1'b0, 5'd0, 32'h0);
        set_p(1'b1, 5'd9, 32'h2);
        cyc();
        chk_wr("waw.p9", 1'b1, 5'd9, 32'h2);
        set_p(1'b0, 5'd0, 32'h0);
        cyc();
        chk("waw.nowrite", 64'(RF_wen_o), 64'd0);
        chk("waw.data_hold", 64'(RF_data_o), 64'h2);

        // WAW against an L accepted the same cycle
        set_p(1'b1, 5'd10, 32'h5);
        set_l(1'b1, 5'd10, 32'h6);
        cyc();
        chk_wr("waw2.p", 1'b1, 5'd10, 32'h5);
        set_p(1'b0, 5'd0, 32'h0);
        set_l(1'b0, 5'd0, 32'h0);
        cyc();
        chk("waw2.nowrite", 64'(RF_wen_o), 64'd0);

        // Reset with two entries buffered and stall asserted
        set_p(1'b1, 5'd1, 32'h100);
        set_l(1'b1, 5'd2, 32'h22);
        cyc();
        set_l(1'b1, 5'd3, 32'h33);
        cyc();
        set_l(1'b0, 5'd0, 32'h0);
        cyc();
        cyc();
        chk("rst2.pre_stall", 64'(stall_o), 64'd1);
        chk("rst2.pre_ready", 64'(L_ready_o), 64'd0);
        #2 rst_n_i = 1'b0;
        #1;
        chk_wr("rst2.async", 1'b0, 5'd0, 32'd0);
        chk("rst2.stall", 64'(stall_o), 64'd0);
        chk("rst2.ready", 64'(L_ready_o), 64'd1);
        set_p(1'b0, 5'd0, 32'h0);
        cyc();
        rst_n_i = 1'b1;
        cyc();
        chk("rst2.nostale1", 64'(RF_wen_o), 64'd0);
        cyc();
        chk("rst2.nostale2", 64'(RF_wen_o), 64'd0);
        chk("rst2.stall_after", 64'(stall_o), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
